alu_div_unit: RTL and testbench

//  Iterative divide/remainder unit for RV32M DIV/DIVU/REM/REMU. Sits beside the

---
 rtl/alu_div_unit.sv | 166 ++++++++++++++++
 tb/tb_alu_div_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_div_unit.sv
// Iterative restoring radix-2 divider for RV32M DIV/DIVU/REM/REMU.
// Produces one quotient bit per clock. Divide-by-zero and signed overflow
// are resolved at acceptance and skip the iteration entirely.
module alu_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kill,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       div_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] div_result,
  output logic             zero_flag
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic             is_rem_q, is_rem_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;

  logic             accept;
  logic             is_signed_in;
  logic             a_neg;
  logic             b_neg;
  logic             div_by_zero;
  logic             overflow;
  logic             special;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] final_val;

  // Two's complement negation, used both for magnitudes and sign fixup.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  // Conditional negation: applies the sign fixup only when requested.
  function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v,
                                                   input logic neg);
    return neg ? negate(v) : v;
  endfunction

  // Operand classification and a single restoring step.
  always_comb begin
    is_signed_in = ~div_op[0];
    a_neg        = is_signed_in && ($signed(in_a) < 0);
    b_neg        = is_signed_in && ($signed(in_b) < 0);
    div_by_zero  = (in_b == '0);
    overflow     = is_signed_in && (in_a == INT_MIN) && (in_b == '1);
    special      = div_by_zero || overflow;
    accept       = in_valid && (state_q == S_IDLE) && !kill;

    shifted  = {rem_q, quo_q[WIDTH-1]};
    fits     = (shifted >= {1'b0, bmag_q});
    step_rem = fits ? (shifted[WIDTH-1:0] - bmag_q) : shifted[WIDTH-1:0];
    step_quo = {quo_q[WIDTH-2:0], fits};
    final_val = is_rem_q ? cond_negate(step_rem, rneg_q)
                         : cond_negate(step_quo, qneg_q);
  end

  // State register, counter and result registers (reset-controlled).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  // Working datapath registers; contents only matter while in CALC.
  always_ff @(posedge clk) begin
    rem_q    <= rem_d;
    quo_q    <= quo_d;
    bmag_q   <= bmag_d;
    is_rem_q <= is_rem_d;
    qneg_q   <= qneg_d;
    rneg_q   <= rneg_d;
  end

  // Next-state logic; kill forces IDLE regardless of handshakes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = special ? S_DONE : S_CALC;
      S_CALC: if (cnt_q == LAST_STEP) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (kill) state_d = S_IDLE;
  end

  // Datapath next values: latch on accept, iterate in CALC, publish at the end.
  always_comb begin
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    bmag_d   = bmag_q;
    is_rem_d = is_rem_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    if (accept) begin
      cnt_d    = '0;
      rem_d    = '0;
      quo_d    = cond_negate(in_a, a_neg);
      bmag_d   = cond_negate(in_b, b_neg);
      is_rem_d = div_op[1];
      qneg_d   = a_neg ^ b_neg;
      rneg_d   = a_neg;
      if (div_by_zero) begin
        result_d = div_op[1] ? in_a : '1;
        zero_d   = div_op[1] ? (in_a == '0) : 1'b0;
      end else if (overflow) begin
        result_d = div_op[1] ? '0 : in_a;
        zero_d   = div_op[1];
      end
    end else if (state_q == S_CALC && !kill) begin
      rem_d = step_rem;
      quo_d = step_quo;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST_STEP) begin
        result_d = final_val;
        zero_d   = (final_val == '0);
      end
    end
  end

  // Handshake outputs decoded from registered state only.
  always_comb begin
    in_ready   = (state_q == S_IDLE);
    out_valid  = (state_q == S_DONE);
    div_result = result_q;
    zero_flag  = zero_q;
  end

endmodule

// File: tb/tb_alu_div_unit.sv
// Testbench for alu_div_unit: directed vector table, handshake corner
// sequences (hold, kill, reset mid-calculation) and random operations
// checked against an arithmetic reference model.
module tb_alu_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         kill;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [1:0]   div_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] div_result;
  logic         zero_flag;

  int errors = 0;
  int checks = 0;

  alu_div_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .kill       (kill),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .div_op     (div_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .div_result (div_result),
    .zero_flag  (zero_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: RISC-V M-extension semantics from plain integer arithmetic.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    int signed sa;
    int signed sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
    case (op)
      2'd0:    return sa / sb;
      2'd1:    return a / b;
      2'd2:    return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    if (b == 32'd0) return 0;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return W;
  endfunction

  // Issue one operation, wait (bounded) for the result, check it and take it.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int n;
    @(negedge clk);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    div_op    = op;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    div_op   = 2'($urandom_range(0, 3));
    n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, " latency"}, 32'(n), 32'(exp_lat));
    check({name, " result"}, div_result, exp);
    check({name, " zero_flag"}, {31'd0, zero_flag}, {31'd0, exp == 32'd0});
    check({name, " in_ready in DONE"}, {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({name, " out_valid drop"}, {31'd0, out_valid}, 32'd0);
    check({name, " in_ready back"}, {31'd0, in_ready}, 32'd1);
  endtask

  vec_t vecs[16];

  initial begin
    logic [31:0] held_res;
    logic        held_zf;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0]  = '{2'd1, 32'd100,        32'd7,          32'd14,         W};
    vecs[1]  = '{2'd3, 32'd100,        32'd7,          32'd2,          W};
    vecs[2]  = '{2'd0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  W};
    vecs[3]  = '{2'd2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  W};
    vecs[4]  = '{2'd1, 32'd5,          32'd0,          32'hFFFF_FFFF,  0};
    vecs[5]  = '{2'd2, 32'd5,          32'd0,          32'd5,          0};
    vecs[6]  = '{2'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0};
    vecs[7]  = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          0};
    vecs[8]  = '{2'd0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  W};
    vecs[9]  = '{2'd2, 32'd7,          32'hFFFF_FFFE,  32'd1,          W};
    vecs[10] = '{2'd3, 32'd0,          32'd5,          32'd0,          W};
    vecs[11] = '{2'd1, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  W};
    vecs[12] = '{2'd0, 32'h8000_0000,  32'd1,          32'h8000_0000,  W};
    vecs[13] = '{2'd1, 32'd0,          32'd0,          32'hFFFF_FFFF,  0};
    vecs[14] = '{2'd2, 32'd0,          32'd0,          32'd0,          0};
    vecs[15] = '{2'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          W};

    rst = 1'b1; kill = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; div_op = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset div_result", div_result, 32'd0);
    check("reset zero_flag", {31'd0, zero_flag}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 16; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    end

    // Result held in DONE while out_ready stays low.
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'd1000; in_b = 32'd33; div_op = 2'd1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (W) @(posedge clk);
    #1;
    held_res = div_result;
    held_zf  = zero_flag;
    check("hold first result", held_res, 32'd30);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      check("hold out_valid", {31'd0, out_valid}, 32'd1);
      check("hold result", div_result, held_res);
      check("hold zero_flag", {31'd0, zero_flag}, {31'd0, held_zf});
      check("hold in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Kill at CALC step 10: back to IDLE, last result retained.
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'hDEAD_BEEF; in_b = 32'd3; div_op = 2'd1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check("kill in_ready", {31'd0, in_ready}, 32'd1);
    check("kill out_valid", {31'd0, out_valid}, 32'd0);
    check("kill keeps result", div_result, held_res);
    repeat (W + 2) @(posedge clk);
    #1;
    check("kill no late valid", {31'd0, out_valid}, 32'd0);

    // Reset at a later CALC step.
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'hFFFF_0000; in_b = 32'd5; div_op = 2'd1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst mid in_ready", {31'd0, in_ready}, 32'd1);
    check("rst mid out_valid", {31'd0, out_valid}, 32'd0);
    check("rst mid result", div_result, 32'd0);
    repeat (W + 2) @(posedge clk);
    #1;
    check("rst no late valid", {31'd0, out_valid}, 32'd0);

    // Kill beats a simultaneous accept.
    @(negedge clk);
    in_valid = 1'b1; kill = 1'b1; in_a = 32'd1; in_b = 32'd0; div_op = 2'd1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; kill = 1'b0;
    check("kill+accept in_ready", {31'd0, in_ready}, 32'd1);
    check("kill+accept out_valid", {31'd0, out_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("kill+accept stays idle", {31'd0, out_valid}, 32'd0);

    run_op("post-kill DIVU 9/3", 2'd1, 32'd9, 32'd3, 32'd3, W);

    // Random operations against the reference model.
    for (int r = 0; r < 40; r++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: rb = rb >> $urandom_range(1, 31);
        default: ;
      endcase
      run_op($sformatf("rand%0d op%0d", r, rop), rop, ra, rb, model(rop, ra, rb),
             model_lat(rop, ra, rb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
